// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter driving the select of a 4:1 data mux with a valid/ready output.
// Optional build macro ARB_FIXED_PRIO_EN switches the IDLE winner to lowest-index fixed priority.
`default_nettype none

module mux_rr_arbiter #(
    parameter int DATA_W   = 4,
    parameter int MAX_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req_in,
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [DATA_W-1:0] c_in,
    input  logic [DATA_W-1:0] d_in,
    input  logic              out_ready_in,
    output logic [1:0]        sel,
    output logic [3:0]        grant_out,
    output logic              out_valid_out,
    output logic [DATA_W-1:0] out,
    output logic              busy_out
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [3:0] C_HOLD_LAST = 4'(MAX_HOLD - 1);

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [3:0]  grant_q, grant_d;
    logic [3:0]  hold_q, hold_d;
    logic [1:0]  winner;
    logic        beat;
`ifndef ARB_FIXED_PRIO_EN
    logic [1:0]  last_q, last_d;
    logic [1:0]  idx;
`endif

    // Scan from highest to lowest priority so the highest-priority requester is written last.
    always_comb begin
        winner = 2'd0;
`ifdef ARB_FIXED_PRIO_EN
        for (int i = 3; i >= 0; i--) begin
            if (req_in[i]) winner = 2'(i);
        end
`else
        idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            idx = last_q + 2'(i + 1);
            if (req_in[idx]) winner = idx;
        end
`endif
    end

    assign beat = out_valid_out & out_ready_in;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        hold_d  = hold_q;
`ifndef ARB_FIXED_PRIO_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (|req_in) begin
                    state_d = GRANT;
                    sel_d   = winner;
                    grant_d = 4'b0001 << winner;
                    hold_d  = 4'd0;
`ifndef ARB_FIXED_PRIO_EN
                    last_d  = winner;
`endif
                end
            end
            GRANT: begin
                if (!req_in[sel_q]) begin
                    state_d = IDLE;
                    grant_d = 4'd0;
                end else if (beat) begin
                    hold_d = hold_q + 4'd1;
                    if (hold_q == C_HOLD_LAST) begin
                        state_d = IDLE;
                        grant_d = 4'd0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            sel_q   <= 2'd0;
            grant_q <= 4'd0;
            hold_q  <= 4'd0;
`ifndef ARB_FIXED_PRIO_EN
            last_q  <= 2'd3;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            hold_q  <= hold_d;
`ifndef ARB_FIXED_PRIO_EN
            last_q  <= last_d;
`endif
        end
    end

    always_comb begin
        case (sel_q)
            2'd0:    out = a_in;
            2'd1:    out = b_in;
            2'd2:    out = c_in;
            default: out = d_in;
        endcase
    end

    assign sel           = sel_q;
    assign grant_out     = grant_q;
    assign busy_out      = (state_q == GRANT);
    assign out_valid_out = (state_q == GRANT) & req_in[sel_q];

endmodule

`default_nettype wire

// File: tb/tb_mux_rr_arbiter.sv
// tb_mux_rr_arbiter: directed table and sequence checks for mux_rr_arbiter (DATA_W=4, MAX_HOLD=4).
`default_nettype none

module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] req_in = 4'd0;
    logic [3:0] a_in = 4'h5, b_in = 4'h6, c_in = 4'h7, d_in = 4'h8;
    logic       out_ready_in = 1'b1;
    logic [1:0] sel;
    logic [3:0] grant_out;
    logic       out_valid_out;
    logic [3:0] out;
    logic       busy_out;

    int n_checks = 0;
    int n_fail   = 0;

    mux_rr_arbiter #(.DATA_W(4), .MAX_HOLD(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_in       (req_in),
        .a_in         (a_in),
        .b_in         (b_in),
        .c_in         (c_in),
        .d_in         (d_in),
        .out_ready_in (out_ready_in),
        .sel          (sel),
        .grant_out    (grant_out),
        .out_valid_out(out_valid_out),
        .out          (out),
        .busy_out     (busy_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic       rdy;
        logic [1:0] e_sel;
        logic [3:0] e_grant;
        logic       e_valid;
        logic       e_busy;
        logic [3:0] e_out;
    } vec_t;

    vec_t vecs[7];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] dsel(input int w);
        return 4'(5 + w);
    endfunction

    task automatic check(input string name, input logic [1:0] es, input logic [3:0] eg,
                         input logic ev, input logic eb, input logic [3:0] eo);
        n_checks++;
        if ({sel, grant_out, out_valid_out, busy_out, out} !== {es, eg, ev, eb, eo}) begin
            n_fail++;
            $display("FAIL %s: got sel=%0d grant=%b valid=%b busy=%b out=%h, expected sel=%0d grant=%b valid=%b busy=%b out=%h",
                     name, sel, grant_out, out_valid_out, busy_out, out, es, eg, ev, eb, eo);
        end
    endtask

    task automatic granted(input string name, input int w);
        check(name, 2'(w), 4'(1 << w), 1'b1, 1'b1, dsel(w));
    endtask

    task automatic idle(input string name, input int w);
        check(name, 2'(w), 4'd0, 1'b0, 1'b0, dsel(w));
    endtask

    task automatic do_reset();
        rst = 1'b1; req_in = 4'd0; out_ready_in = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    initial begin
        int order[5];
        int fp[3];

        //            rst   req      rdy   sel  grant    v     b     out
        vecs[0] = '{1'b1, 4'b0000, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, 4'h5};
        vecs[1] = '{1'b0, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, 4'h5};
        vecs[2] = '{1'b0, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, 4'h5};
        vecs[3] = '{1'b0, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, 4'h5};
        vecs[4] = '{1'b0, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, 4'h5};
        vecs[5] = '{1'b0, 4'b0001, 1'b1, 2'd0, 4'b0000, 1'b0, 1'b0, 4'h5};
        vecs[6] = '{1'b0, 4'b0001, 1'b1, 2'd0, 4'b0001, 1'b1, 1'b1, 4'h5};

        // Single requester: reset, grant, four beats, one bubble, re-grant.
        for (int i = 0; i < 7; i++) begin
            rst = vecs[i].rst; req_in = vecs[i].req; out_ready_in = vecs[i].rdy;
            cyc();
            check($sformatf("vec%0d", i), vecs[i].e_sel, vecs[i].e_grant,
                  vecs[i].e_valid, vecs[i].e_busy, vecs[i].e_out);
        end

        // All four requesting: rotation 0,1,2,3,0 with 4-beat bursts and one idle cycle.
        order = '{0, 1, 2, 3, 0};
        do_reset();
        req_in = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            cyc();
            granted($sformatf("rr_grant%0d", k), order[k]);
            for (int b = 0; b < 3; b++) begin
                cyc();
                granted($sformatf("rr_hold%0d_%0d", k, b), order[k]);
            end
            cyc();
            idle($sformatf("rr_bubble%0d", k), order[k]);
        end

        // Requester 2 drops after two beats; requester 3 is next in rotation.
        do_reset();
        req_in = 4'b0100;
        cyc(); granted("drop_grant", 2);
        cyc(); granted("drop_beat1", 2);
        cyc(); granted("drop_beat2", 2);
        req_in = 4'b1000;
        cyc(); idle("drop_release", 2);
        cyc(); granted("drop_next3", 3);

        // Stalled burst never times out; four beats still needed once ready returns.
        do_reset();
        req_in = 4'b0001; out_ready_in = 1'b0;
        cyc(); granted("stall_grant", 0);
        for (int s = 0; s < 10; s++) begin
            cyc(); granted($sformatf("stall%0d", s), 0);
        end
        out_ready_in = 1'b1;
        for (int b = 0; b < 3; b++) begin
            cyc(); granted($sformatf("stall_beat%0d", b), 0);
        end
        cyc(); idle("stall_release", 0);

        // Reset mid-burst while requester 2 holds the channel.
        do_reset();
        req_in = 4'b0100;
        cyc(); granted("mid_grant2", 2);
        cyc(); granted("mid_beat", 2);
        rst = 1'b1; req_in = 4'b1111;
        cyc(); check("mid_reset", 2'd0, 4'd0, 1'b0, 1'b0, 4'h5);
        rst = 1'b0;
        cyc(); granted("post_reset_grant0", 0);

        // Requesters 1 and 3 competing.
`ifdef ARB_FIXED_PRIO_EN
        fp = '{1, 1, 1};
`else
        fp = '{1, 3, 1};
`endif
        do_reset();
        req_in = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            cyc(); granted($sformatf("p1010_grant%0d", k), fp[k]);
            for (int b = 0; b < 3; b++) cyc();
            cyc(); idle($sformatf("p1010_bubble%0d", k), fp[k]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
